button_events: RTL and testbench

//  Downstream of the button debouncer. Consumes its clean per-button levels and

---
 rtl/btn_pkg.sv | 31 +++
 rtl/button_event_chan.sv | 132 +++++++++++++
 rtl/button_events.sv | 63 ++++++
 tb/tb_button_events.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/btn_pkg.sv
// btn_pkg: types and constants shared by the button_events top and its channels.
// Holds the per-channel FSM encoding, hold-counter width and a saturating increment.
package btn_pkg;

  // Hold counter width; hold counters saturate instead of wrapping.
  localparam int HOLD_W = 16;

  // Width of the shared free-running tick divider.
  localparam int TICK_W = 32;

  typedef logic [HOLD_W-1:0] hold_t;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PRESSED = 2'd1,
    ST_LONG    = 2'd2
  } chan_state_e;

  // Increment that sticks at all-ones so a very long hold cannot wrap back
  // through a threshold and fire a spurious event.
  function automatic hold_t hold_sat_inc(input hold_t v);
    hold_t r;
    if (v == {HOLD_W{1'b1}}) begin
      r = v;
    end else begin
      r = v + hold_t'(1);
    end
    return r;
  endfunction

endpackage

// File: rtl/button_event_chan.sv
// button_event_chan: one button channel. Tracks the previous level, runs the
// IDLE/PRESSED/LONG FSM on the shared tick and emits registered one-cycle
// press / release / long / repeat strobes plus a registered copy of the level.
// Optional feature macro: BUTTON_EVENTS_REPEAT_EN (auto-repeat strobes in LONG).
module button_event_chan
  import btn_pkg::*;
#(
  parameter int LONG_TICKS   = 500,
  parameter int REPEAT_TICKS = 100
) (
  input  logic clk,
  input  logic rst_n,
  input  logic tick,
  input  logic lvl_i,
  output logic press_o,
  output logic release_o,
  output logic long_o,
  output logic rpt_o,
  output logic held_o
);

`ifdef BUTTON_EVENTS_REPEAT_EN
  localparam bit REPEAT_EN = 1'b1;
`else
  // Without auto-repeat the rpt strobe can never be set, so it stays 0 and
  // LONG simply keeps counting (saturating) until the button is released.
  localparam bit REPEAT_EN = 1'b0;
`endif

  localparam hold_t LONG_THR = hold_t'(LONG_TICKS);
  localparam hold_t RPT_THR  = hold_t'(REPEAT_TICKS);

  logic        prev_q, prev_d;
  logic        held_q, held_d;
  chan_state_e state_q, state_d;
  hold_t       hold_cnt_q, hold_cnt_d;
  logic        press_q, press_d;
  logic        release_q, release_d;
  logic        long_q, long_d;
  logic        rpt_q, rpt_d;

  logic        rise;
  logic        fall;
  hold_t       hold_inc;

  // Next-state, hold counting and strobe decode; release always wins so a
  // release landing on a threshold tick never also reports long/rpt.
  always_comb begin
    prev_d     = lvl_i;
    held_d     = lvl_i;
    state_d    = state_q;
    hold_cnt_d = hold_cnt_q;
    press_d    = 1'b0;
    release_d  = 1'b0;
    long_d     = 1'b0;
    rpt_d      = 1'b0;
    rise       = lvl_i & ~prev_q;
    fall       = ~lvl_i & prev_q;
    hold_inc   = hold_sat_inc(hold_cnt_q);

    if (fall) begin
      release_d  = 1'b1;
      hold_cnt_d = '0;
      state_d    = ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (rise) begin
            press_d    = 1'b1;
            hold_cnt_d = '0;
            state_d    = ST_PRESSED;
          end
        end
        ST_PRESSED: begin
          if (tick) begin
            if (hold_inc == LONG_THR) begin
              long_d     = 1'b1;
              hold_cnt_d = '0;
              state_d    = ST_LONG;
            end else begin
              hold_cnt_d = hold_inc;
            end
          end
        end
        ST_LONG: begin
          if (tick) begin
            if (REPEAT_EN && (hold_inc == RPT_THR)) begin
              rpt_d      = 1'b1;
              hold_cnt_d = '0;
            end else begin
              hold_cnt_d = hold_inc;
            end
          end
        end
        default: begin
          state_d    = ST_IDLE;
          hold_cnt_d = '0;
        end
      endcase
    end
  end

  // Channel registers; reset clears strobes immediately and emits no release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_q     <= 1'b0;
      held_q     <= 1'b0;
      state_q    <= ST_IDLE;
      hold_cnt_q <= '0;
      press_q    <= 1'b0;
      release_q  <= 1'b0;
      long_q     <= 1'b0;
      rpt_q      <= 1'b0;
    end else begin
      prev_q     <= prev_d;
      held_q     <= held_d;
      state_q    <= state_d;
      hold_cnt_q <= hold_cnt_d;
      press_q    <= press_d;
      release_q  <= release_d;
      long_q     <= long_d;
      rpt_q      <= rpt_d;
    end
  end

  assign press_o   = press_q;
  assign release_o = release_q;
  assign long_o    = long_q;
  assign rpt_o     = rpt_q;
  assign held_o    = held_q;

endmodule

// File: rtl/button_events.sv
// button_events: turns debounced button levels into one-cycle press, release,
// long-press and auto-repeat strobes. One free-running tick divider is shared
// by all channels; each channel runs its own button_event_chan instance.
// The release strobe port is named release_o because "release" is a reserved
// word in SystemVerilog.
// Optional feature macro: BUTTON_EVENTS_REPEAT_EN (auto-repeat strobes on rpt).
module button_events
  import btn_pkg::*;
#(
  parameter int WIDTH        = 1,
  parameter int CDIV         = 50_000,
  parameter int LONG_TICKS   = 500,
  parameter int REPEAT_TICKS = 100
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] lvl,
  output logic [WIDTH-1:0] press,
  output logic [WIDTH-1:0] release_o,
  output logic [WIDTH-1:0] long,
  output logic [WIDTH-1:0] rpt,
  output logic [WIDTH-1:0] held
);

  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(CDIV - 1);

  logic [TICK_W-1:0] tick_cnt_q, tick_cnt_d;
  logic              tick;

  // Free-running divider: tick marks the last count, then the counter wraps.
  // Presses never restart it, which is why long-press timing is quantised.
  always_comb begin
    tick       = (tick_cnt_q == TICK_LAST);
    tick_cnt_d = tick ? '0 : tick_cnt_q + TICK_W'(1);
  end

  // Divider register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_cnt_q <= '0;
    end else begin
      tick_cnt_q <= tick_cnt_d;
    end
  end

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_chan
    button_event_chan #(
      .LONG_TICKS   (LONG_TICKS),
      .REPEAT_TICKS (REPEAT_TICKS)
    ) u_chan (
      .clk       (clk),
      .rst_n     (rst_n),
      .tick      (tick),
      .lvl_i     (lvl[gi]),
      .press_o   (press[gi]),
      .release_o (release_o[gi]),
      .long_o    (long[gi]),
      .rpt_o     (rpt[gi]),
      .held_o    (held[gi])
    );
  end

endmodule

// File: tb/tb_button_events.sv
// tb_button_events: directed bench for button_events with CDIV=4, LONG_TICKS=3,
// REPEAT_TICKS=2, WIDTH=2. A tick-counting model predicts every output each cycle;
// literal checks after each scenario pin the model's timing.
`timescale 1ns/1ps
module tb_button_events;

  localparam int W      = 2;
  localparam int CDIV   = 4;
  localparam int LONG_T = 3;
  localparam int RPT_T  = 2;
`ifdef BUTTON_EVENTS_REPEAT_EN
  localparam bit REP = 1'b1;
`else
  localparam bit REP = 1'b0;
`endif

  logic         clk;
  logic         rst_n;
  logic [W-1:0] lvl;
  logic [W-1:0] press, release_o, long_s, rpt, held;

  button_events #(
    .WIDTH        (W),
    .CDIV         (CDIV),
    .LONG_TICKS   (LONG_T),
    .REPEAT_TICKS (RPT_T)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .lvl       (lvl),
    .press     (press),
    .release_o (release_o),
    .long      (long_s),
    .rpt       (rpt),
    .held      (held)
  );

  int checks   = 0;
  int failures = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Counts ticks seen since the press: long at LONG_T ticks, repeats at
  // LONG_T + k*RPT_T ticks; the tick is edge_index % CDIV == CDIV-1.
  int           cyc;
  bit           m_prev [W];
  bit           m_hold [W];
  int           m_ticks[W];
  logic [W-1:0] e_press, e_rel, e_long, e_rpt, e_held;

  initial begin
    cyc = 0;
    e_press = '0; e_rel = '0; e_long = '0; e_rpt = '0; e_held = '0;
    for (int c = 0; c < W; c++) begin
      m_prev[c] = 1'b0; m_hold[c] = 1'b0; m_ticks[c] = 0;
    end
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        cyc = 0;
        e_press = '0; e_rel = '0; e_long = '0; e_rpt = '0; e_held = '0;
        for (int c = 0; c < W; c++) begin
          m_prev[c] = 1'b0; m_hold[c] = 1'b0; m_ticks[c] = 0;
        end
      end else begin
        logic m_tick;
        m_tick = ((cyc % CDIV) == CDIV - 1);
        e_press = '0; e_rel = '0; e_long = '0; e_rpt = '0;
        for (int c = 0; c < W; c++) begin
          if (!lvl[c] && m_prev[c]) begin
            e_rel[c]   = 1'b1;
            m_hold[c]  = 1'b0;
            m_ticks[c] = 0;
          end else if (lvl[c] && !m_prev[c]) begin
            e_press[c] = 1'b1;
            m_hold[c]  = 1'b1;
            m_ticks[c] = 0;
          end else if (m_hold[c] && m_tick) begin
            m_ticks[c]++;
            if (m_ticks[c] == LONG_T)
              e_long[c] = 1'b1;
            else if (REP && m_ticks[c] > LONG_T && ((m_ticks[c] - LONG_T) % RPT_T) == 0)
              e_rpt[c] = 1'b1;
          end
          m_prev[c] = lvl[c];
        end
        e_held = lvl;
        cyc++;
      end
    end
  end

  // ---------------- compare + event log ----------------
  int n_press[W], n_rel[W], n_long[W], n_rpt[W];
  int t_press[W], t_rel[W], t_long[W], t_rpt[W], rpt_gap[W];
  int n_both;

  initial begin
    n_both = 0;
    for (int c = 0; c < W; c++) begin
      n_press[c] = 0; n_rel[c] = 0; n_long[c] = 0; n_rpt[c] = 0;
      t_press[c] = 0; t_rel[c] = 0; t_long[c] = 0; t_rpt[c] = 0; rpt_gap[c] = 0;
    end
    forever begin
      @(negedge clk);
      chk("press", 32'(press), 32'(e_press));
      chk("release", 32'(release_o), 32'(e_rel));
      chk("long", 32'(long_s), 32'(e_long));
      chk("rpt", 32'(rpt), 32'(e_rpt));
      chk("held", 32'(held), 32'(e_held));
      for (int c = 0; c < W; c++) begin
        if (press[c] === 1'b1)     begin n_press[c]++; t_press[c] = cyc; end
        if (release_o[c] === 1'b1) begin n_rel[c]++;   t_rel[c]   = cyc; end
        if (long_s[c] === 1'b1)    begin n_long[c]++;  t_long[c]  = cyc; end
        if (rpt[c] === 1'b1) begin
          if (n_rpt[c] > 0) rpt_gap[c] = cyc - t_rpt[c];
          t_rpt[c] = cyc;
          n_rpt[c]++;
        end
      end
      if (press === 2'b11) n_both++;
    end
  end

  // ---------------- directed stimulus ----------------
  int b_press[W], b_rel[W], b_long[W], b_rpt[W];
  int r_edge, e_edge, nt, guard;

  task automatic snap();
    for (int c = 0; c < W; c++) begin
      b_press[c] = n_press[c]; b_rel[c] = n_rel[c];
      b_long[c]  = n_long[c];  b_rpt[c] = n_rpt[c];
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    lvl   = '0;
    rst_n = 1'b0;
    cycles(3);
    chk("reset_outputs", 32'({press, release_o, long_s, rpt, held}), 32'd0);
    rst_n = 1'b1;
    cycles(4);

    // 1: short tap on channel 0
    snap();
    lvl[0] = 1'b1; cycles(5);
    lvl[0] = 1'b0; cycles(4);
    chk("t1_press_cnt", n_press[0] - b_press[0], 1);
    chk("t1_release_cnt", n_rel[0] - b_rel[0], 1);
    chk("t1_long_cnt", n_long[0] - b_long[0], 0);
    chk("t1_rpt_cnt", n_rpt[0] - b_rpt[0], 0);
    $display("T1 tap: press=%0d release=%0d long=%0d", n_press[0] - b_press[0],
             n_rel[0] - b_rel[0], n_long[0] - b_long[0]);

    // 2: long hold of 20 cycles
    snap();
    lvl[0] = 1'b1; cycles(20);
    lvl[0] = 1'b0; cycles(4);
    chk("t2_long_cnt", n_long[0] - b_long[0], 1);
    chk("t2_long_after_press_ge9", 32'(t_long[0] - t_press[0] >= 9), 1);
    chk("t2_long_after_press_le12", 32'(t_long[0] - t_press[0] <= 12), 1);
    chk("t2_release_cnt", n_rel[0] - b_rel[0], 1);
    $display("T2 long hold: long %0d cycles after press", t_long[0] - t_press[0]);

    // 3: 40-cycle hold, repeats every RPT_T*CDIV cycles when enabled
    snap();
    lvl[0] = 1'b1; cycles(40);
    lvl[0] = 1'b0; cycles(4);
    chk("t3_long_cnt", n_long[0] - b_long[0], 1);
`ifdef BUTTON_EVENTS_REPEAT_EN
    chk("t3_rpt_cnt_ge3", 32'((n_rpt[0] - b_rpt[0]) >= 3), 1);
    chk("t3_rpt_gap", rpt_gap[0], 8);
`else
    chk("t3_rpt_cnt", n_rpt[0] - b_rpt[0], 0);
`endif
    $display("T3 repeat: rpt=%0d gap=%0d", n_rpt[0] - b_rpt[0], rpt_gap[0]);

    // 4: release sampled on the exact edge where long would fire
    snap();
    r_edge = cyc;
    lvl[0] = 1'b1;
    nt = 0;
    e_edge = r_edge + 1;
    while (1) begin
      if ((e_edge % CDIV) == CDIV - 1) begin
        nt++;
        if (nt == LONG_T) break;
      end
      e_edge++;
    end
    guard = 0;
    while (cyc < e_edge && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    chk("t4_reach_threshold", 32'(cyc), 32'(e_edge));
    lvl[0] = 1'b0;
    cycles(4);
    chk("t4_long_cnt", n_long[0] - b_long[0], 0);
    chk("t4_release_cnt", n_rel[0] - b_rel[0], 1);
    chk("t4_release_edge", t_rel[0], e_edge + 1);
    $display("T4 release on threshold: edge=%0d long=%0d", e_edge, n_long[0] - b_long[0]);

    // 5: both channels pressed together, channel 1 released early
    snap();
    guard = n_both;
    lvl = 2'b11; cycles(6);
    lvl = 2'b01; cycles(12);
    lvl = 2'b00; cycles(4);
    chk("t5_press_both", n_both - guard, 1);
    chk("t5_long_ch0", n_long[0] - b_long[0], 1);
    chk("t5_long_ch1", n_long[1] - b_long[1], 0);
    chk("t5_release_ch1", n_rel[1] - b_rel[1], 1);
    $display("T5 dual press: both=%0d long0=%0d long1=%0d", n_both - guard,
             n_long[0] - b_long[0], n_long[1] - b_long[1]);

    // 6: asynchronous reset while channel 0 is in LONG
    lvl = 2'b01; cycles(16);
    #2;
    chk("t6_held_before_reset", 32'(held), 32'h1);
    rst_n = 1'b0;
    #1;
    chk("t6_async_reset_outputs", 32'({press, release_o, long_s, rpt, held}), 32'd0);
    cycles(2);
    rst_n = 1'b1;
    cycles(1);
    chk("t6_press_after_reset", 32'(press), 32'h1);
    $display("T6 reset mid-long: press after reset=%b", press);
    lvl = '0; cycles(4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
